// File: rtl/intc_pkg.sv
// Shared constants and types for the interrupt controller.
// Register map, FSM encoding and request count.
package intc_pkg;

  localparam int NIRQ = 8;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_ISR  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CALL,
    S_SERVICE
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: bit 0 wins.
// Reports whether any bit is set and its index.
module intc_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // lowest set bit selects the index
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    priority case (1'b1)
      req[0]: idx = 3'd0;
      req[1]: idx = 3'd1;
      req[2]: idx = 3'd2;
      req[3]: idx = 3'd3;
      req[4]: idx = 3'd4;
      req[5]: idx = 3'd5;
      req[6]: idx = 3'd6;
      req[7]: idx = 3'd7;
      default: idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller, 8 edge-triggered lines.
// Define INTC_NEST_EN to allow higher-priority preemption.
import intc_pkg::*;

module int_ctrl #(
  parameter int NIRQ = intc_pkg::NIRQ
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            INTA,
  input  logic            ret,
  input  logic            WE,
  input  logic [1:0]      ADDR,
  input  logic [7:0]      WDATA,
  output logic [7:0]      RDATA,
  output logic            interrupt,
  output logic            CallInt,
  output logic [2:0]      VEC
);

  logic [7:0] mask;
  logic [7:0] pend;
  logic [7:0] isr;
  logic [7:0] irq_q;
  logic       gie;
  state_t     state;
  state_t     state_nx;

  logic [7:0] elig;
  logic       ev;
  logic [2:0] ei;
  logic       iv;
  logic [2:0] ii;
  logic       can_take;
  logic       take;
  logic       done;
  logic [7:0] irq_edge;
  logic [7:0] ei_oh;
  logic [7:0] ii_oh;
  logic [7:0] w1c;
  logic [7:0] take_clr;
  logic [7:0] done_clr;

  assign elig     = pend & mask & {8{gie}};
  assign irq_edge = IRQ & ~irq_q;
  assign ei_oh    = 8'b1 << ei;
  assign ii_oh    = 8'b1 << ii;

  // a request only wins over the current service if strictly higher
  assign can_take = ev && (!iv || (ei < ii));
  assign take     = (state == S_REQ) && can_take && INTA;
  assign done     = (state == S_SERVICE) && ret;

  assign w1c      = (WE && ADDR == A_PEND) ? WDATA : 8'h00;
  assign take_clr = take ? ei_oh : 8'h00;
  assign done_clr = done ? ii_oh : 8'h00;

  intc_prio_enc u_elig (
    .req   (elig),
    .valid (ev),
    .idx   (ei)
  );

  intc_prio_enc u_isr (
    .req   (isr),
    .valid (iv),
    .idx   (ii)
  );

  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (can_take) state_nx = S_REQ;
      end
      S_REQ: begin
        if (!can_take)
          state_nx = iv ? S_SERVICE : S_IDLE;
        else if (INTA)
          state_nx = S_CALL;
      end
      S_CALL: begin
        state_nx = S_SERVICE;
      end
      S_SERVICE: begin
        if (ret)
          state_nx = |(isr & ~ii_oh) ? S_SERVICE : S_IDLE;
`ifdef INTC_NEST_EN
        else if (can_take)
          state_nx = S_REQ;
`else
        else
          state_nx = S_SERVICE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // registered handshake outputs and taken vector
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      interrupt <= 1'b0;
      CallInt   <= 1'b0;
      VEC       <= 3'd0;
    end else begin
      interrupt <= (state_nx == S_REQ);
      CallInt   <= (state_nx == S_CALL);
      if (take) VEC <= ei;
    end
  end

  // edge history; zero at reset so a high line counts
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) irq_q <= 8'h00;
    else       irq_q <= IRQ;
  end

  // software-visible registers; edge set beats clear
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mask <= 8'h00;
      pend <= 8'h00;
      isr  <= 8'h00;
      gie  <= 1'b0;
    end else begin
      if (WE && ADDR == A_MASK) mask <= WDATA;
      if (WE && ADDR == A_CTRL) gie  <= WDATA[0];
      pend <= (pend & ~w1c & ~take_clr) | irq_edge;
      isr  <= (isr | take_clr) & ~done_clr;
    end
  end

  // combinational read port
  always_comb begin
    RDATA = 8'h00;
    unique case (ADDR)
      A_MASK: RDATA = mask;
      A_PEND: RDATA = pend;
      A_ISR:  RDATA = isr;
      A_CTRL: RDATA = {7'b0, gie};
      default: RDATA = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl.
// Directed scenarios plus random traffic vs a flag model.
module tb_int_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [7:0] IRQ;
  logic       INTA;
  logic       ret;
  logic       WE;
  logic [1:0] ADDR;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       interrupt;
  logic       CallInt;
  logic [2:0] VEC;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mask, m_pend, m_isr, m_prev;
  logic       m_gie;
  logic [2:0] m_vec;
  bit         m_int, m_call, m_svc;
  logic [7:0] irq_cur;

  int_ctrl dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .IRQ       (IRQ),
    .INTA      (INTA),
    .ret       (ret),
    .WE        (WE),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .RDATA     (RDATA),
    .interrupt (interrupt),
    .CallInt   (CallInt),
    .VEC       (VEC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return m_isr;
      default: return {7'b0, m_gie};
    endcase
  endfunction

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_isr = 0; m_prev = 0;
    m_gie = 0; m_vec = 0;
    m_int = 0; m_call = 0; m_svc = 0;
  endtask

  task automatic model_step(input logic [7:0] irq,
                            input logic i_a, input logic r,
                            input logic we, input logic [1:0] a,
                            input logic [7:0] wd);
    logic [7:0] elig, n_pend, n_isr, edges;
    int h, t;
    bit n_int, n_call, n_svc, takeable;
    edges  = irq & ~m_prev;
    elig   = m_pend & m_mask & (m_gie ? 8'hff : 8'h00);
    h      = lowest(elig);
    t      = lowest(m_isr);
    takeable = (h < 8) && (h < t);
    n_pend = m_pend; n_isr = m_isr;
    n_int = 0; n_call = 0; n_svc = m_svc;
    if (m_int) begin
      if (!takeable) n_svc = (m_isr != 0);
      else if (i_a) begin
        m_vec = h[2:0];
        n_pend[h] = 1'b0;
        n_isr[h]  = 1'b1;
        n_call = 1;
      end else n_int = 1;
    end else if (m_call) begin
      n_svc = 1;
    end else if (m_svc) begin
      if (r) begin
        n_isr[t] = 1'b0;
        n_svc = (n_isr != 0);
      end
`ifdef INTC_NEST_EN
      else if (takeable) begin
        n_svc = 0;
        n_int = 1;
      end
`endif
    end else if (elig != 0) begin
      n_int = 1;
    end
    if (we && a == 2'd1) n_pend &= ~wd;
    if (we && a == 2'd0) m_mask = wd;
    if (we && a == 2'd3) m_gie = wd[0];
    m_pend = n_pend | edges;
    m_isr  = n_isr;
    m_prev = irq;
    m_int = n_int; m_call = n_call; m_svc = n_svc;
  endtask

  // called just after a falling edge
  task automatic cycle(input logic [7:0] irq,
                       input logic i_a, input logic r,
                       input logic we, input logic [1:0] a,
                       input logic [7:0] wd);
    IRQ = irq; INTA = i_a; ret = r;
    WE = we; ADDR = a; WDATA = wd;
    irq_cur = irq;
    #1;
    check("rd_pre", RDATA, model_rd(a));
    model_step(irq, i_a, r, we, a, wd);
    @(negedge CLK);
    check("interrupt", interrupt, m_int);
    check("callint", CallInt, m_call);
    check("vec", VEC, m_vec);
    check("rdata", RDATA, model_rd(a));
  endtask

  task automatic tick(input logic [1:0] a);
    cycle(irq_cur, 1'b0, 1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cycle(irq_cur, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic set_irq(input logic [7:0] v);
    cycle(v, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
  endtask

  task automatic ack();
    cycle(irq_cur, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
  endtask

  task automatic do_ret();
    cycle(irq_cur, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
  endtask

  task automatic wait_int(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (interrupt) break;
      tick(2'd1);
    end
    check(tag, interrupt, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_int"}, interrupt, 1'b0);
    check({tag, "_call"}, CallInt, 1'b0);
    check({tag, "_vec"}, VEC, 3'd0);
    for (int a = 0; a < 4; a++) begin
      ADDR = a[1:0];
      #1;
      check({tag, "_reg"}, RDATA, 8'h00);
    end
  endtask

  initial begin
    RSTn = 1'b0;
    IRQ = 0; INTA = 0; ret = 0; WE = 0; ADDR = 0; WDATA = 0;
    irq_cur = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RSTn = 1'b1;

    // single request, full take sequence
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h01);
    set_irq(8'h01);
    check("d1_pend", RDATA, 8'h01);
    check("d1_int_lo", interrupt, 1'b0);
    tick(2'd1);
    check("d1_int_hi", interrupt, 1'b1);
    ack();
    check("d1_call", CallInt, 1'b1);
    check("d1_vec", VEC, 3'd0);
    tick(2'd1);
    check("d1_pend0", RDATA, 8'h00);
    check("d1_call0", CallInt, 1'b0);
    tick(2'd2);
    check("d1_isr", RDATA, 8'h01);
    do_ret();
    check("d1_isr0", RDATA, 8'h00);
    tick(2'd1);
    check("d1_level", RDATA, 8'h00);

    // two simultaneous edges, priority order
    set_irq(8'h00);
    wr(2'd0, 8'hff);
    set_irq(8'h28);
    wait_int("d2_int1");
    ack();
    check("d2_vec3", VEC, 3'd3);
    tick(2'd2);
    do_ret();
    wait_int("d2_int2");
    ack();
    check("d2_vec5", VEC, 3'd5);
    tick(2'd2);
    do_ret();
    check("d2_isr0", RDATA, 8'h00);

    // masked before acknowledge
    set_irq(8'h00);
    set_irq(8'h04);
    wait_int("d3_int");
    wr(2'd0, 8'hfb);
    tick(2'd2);
    tick(2'd2);
    check("d3_int_drop", interrupt, 1'b0);
    check("d3_isr", RDATA, 8'h00);
    cycle(irq_cur, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
    check("d3_ignored", CallInt, 1'b0);
    check("d3_pend", RDATA[2], 1'b1);
    wr(2'd1, 8'hff);

    // clear and edge on the same bit
    wr(2'd0, 8'h00);
    set_irq(8'h00);
    cycle(8'h04, 1'b0, 1'b0, 1'b1, 2'd1, 8'h04);
    check("d4_pend", RDATA[2], 1'b1);
    wr(2'd1, 8'hff);

    // higher request during service
    wr(2'd0, 8'hff);
    set_irq(8'h00);
    set_irq(8'h10);
    wait_int("d5_int");
    ack();
    check("d5_vec", VEC, 3'd4);
    tick(2'd2);
    check("d5_isr", RDATA, 8'h10);
    set_irq(8'h12);
`ifdef INTC_NEST_EN
    wait_int("d5_preempt");
    ack();
    check("d5_vec1", VEC, 3'd1);
    tick(2'd2);
    check("d5_isr2", RDATA, 8'h12);
    do_ret();
    check("d5_isr_a", RDATA, 8'h10);
    tick(2'd2);
    check("d5_noint", interrupt, 1'b0);
    do_ret();
    check("d5_isr_b", RDATA, 8'h00);
    tick(2'd2);
    check("d5_idle", interrupt, 1'b0);
`else
    repeat (4) tick(2'd2);
    check("d5_nopre", interrupt, 1'b0);
    check("d5_isr1", RDATA, 8'h10);
    do_ret();
    wait_int("d5_late");
    ack();
    check("d5_vec1", VEC, 3'd1);
    tick(2'd2);
    check("d5_isr2", RDATA, 8'h02);
    do_ret();
    check("d5_isr0", RDATA, 8'h00);
`endif

    // reset while in CALL
    set_irq(8'h00);
    set_irq(8'h01);
    wait_int("d6_int");
    ack();
    check("d6_call", CallInt, 1'b1);
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    chk_all_zero("d6");
    @(negedge CLK);
    irq_cur = IRQ;
    RSTn = 1'b1;

    // random traffic
    wr(2'd3, 8'h01);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] flip, d;
      logic [1:0] a;
      flip = 0;
      for (int b = 0; b < 8; b++)
        flip[b] = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd3) d[0] = ($urandom_range(0, 3) != 0);
      cycle(irq_cur ^ flip,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NIRQ, default 8: number of interrupt request lines, fixed at 8 in this revision.
REQ-002 CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 IRQ  input  8  peripheral requests, synchronous to CLK, rising-edge sensitive.
REQ-005 INTA  input  1  CPU accepts a pending interrupt at an instruction boundary; one-cycle pulse.
REQ-006 ret  input  1  return-from-interrupt pulse from the control unit.
REQ-007 WE  input  1  register write strobe.
REQ-008 ADDR  input  2  register select.
REQ-009 WDATA  input  8  write data.
REQ-010 RDATA  output  8  combinational read data for ADDR.
REQ-011 interrupt  output  1  request to the control unit, registered.
REQ-012 CallInt  output  1  one-cycle strobe forcing the PC-push bus write, registered.
REQ-013 VEC  output  3  index of the interrupt being taken, registered.

Function
REQ-014 Registers: ADDR 0 MASK (R/W); 1 PEND (read; write-1-to-clear); 2 ISR (read-only); 3 CTRL (bit0 GIE, R/W; bits 7:1 read 0).
REQ-015 A 0->1 transition of IRQ[i] between consecutive cycles SHALL set PEND[i] on the next edge; a level held high sets it only once.
REQ-016 A same-cycle edge set and write-1-clear on one PEND bit SHALL leave the bit set.
REQ-017 Priority is fixed: lower index is higher priority; "eligible" = PEND & MASK & {8{GIE}}.
REQ-018 FSM states IDLE, REQ, CALL, SERVICE; reset state IDLE.
REQ-019 IDLE -> REQ when eligible != 0; interrupt is high exactly in REQ.
REQ-020 In REQ with eligible == 0 (masked or cleared before INTA), the FSM SHALL return to IDLE (or SERVICE if ISR != 0) with no side effects.
REQ-021 In REQ with INTA high: VEC <= highest-priority eligible index, PEND bit cleared, ISR bit set, -> CALL.
REQ-022 CALL lasts exactly one cycle with CallInt = 1, then -> SERVICE; CallInt is 0 in every other state.
REQ-023 In SERVICE, ret SHALL clear the highest-priority set ISR bit; next state SERVICE if ISR remains non-zero, else IDLE.
REQ-024 ret outside SERVICE, or INTA outside REQ, SHALL be ignored.
REQ-025 ret and a new IRQ edge in the same cycle SHALL both take effect.
REQ-026 VEC holds its value until the next take.

Reset
REQ-027 RSTn low SHALL immediately clear MASK, PEND, ISR, GIE, VEC, interrupt and CallInt and force IDLE, including mid-CALL or mid-SERVICE.
REQ-028 The edge-detect history register SHALL reset to 0, so IRQ high at reset release counts as an edge.

Configuration
REQ-029 Macro INTC_NEST_EN defined: in SERVICE, an eligible request of strictly higher priority than the highest set ISR bit SHALL move the FSM to REQ (preemption); ISR may hold several bits.
REQ-030 Macro INTC_NEST_EN undefined: SERVICE leaves only on ret; at most one ISR bit is ever set; pending requests wait.

Structure
REQ-031 Register address constants, FSM state encoding and NIRQ SHALL live in the shared package intc_pkg.
REQ-032 One sub-module, intc_prio_enc (8-bit fixed-priority encoder: valid and index), SHALL be used for both eligible selection and ISR clearing.

Verification
REQ-033 MASK=0x01, GIE=1, IRQ[0] rises -> PEND=0x01 next cycle, interrupt=1 the cycle after; INTA -> CallInt one cycle, VEC=0, ISR=0x01, PEND=0x00.
REQ-034 IRQ[3] and IRQ[5] rise together, MASK=0xFF -> VEC=3 first; after ret, VEC=5 is taken next.
REQ-035 IRQ[2] pending, then MASK[2] cleared before INTA -> interrupt drops, ISR stays 0, PEND[2] stays 1.
REQ-036 Write 0x04 to PEND in the same cycle as an IRQ[2] edge -> PEND[2]=1.
REQ-037 INTC_NEST_EN: servicing VEC=4, IRQ[1] rises -> preempt, ISR=0x12; first ret -> ISR=0x10 in SERVICE; second ret -> IDLE. Without the macro: no preemption, ISR never exceeds one bit.
REQ-038 RSTn asserted during CALL -> CallInt, interrupt, ISR and all registers 0 asynchronously, FSM in IDLE.
